// File: rtl/fa_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// fa_serial_add_ctrl
//
// Bit-serial WIDTH-bit adder sequencer built around a single shared full
// adder (fa_using_ha). On an accepted start the two operands and the
// carry-in are captured, then fed LSB-first through the full adder, one bit
// per clock. The running carry lives in a flip-flop between cycles and the
// sum bits are gathered in a right-shifting register. The final sum and
// carry are published together with a one-cycle done pulse.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - operation request, only looked at in IDLE
//   a, b   - WIDTH-bit operands, captured on the accepting edge
//   c_in   - carry-in, captured on the accepting edge
//   busy   - high while bits are being processed (RUN)
//   done   - one-cycle completion pulse (DONE)
//   sum    - registered result, held between operations
//   c_out  - registered final carry, held between operations
//
// Also contains the half adder and the fa_using_ha full adder so the
// controller is self-contained.
// ---------------------------------------------------------------------------

module ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

module fa_using_ha (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c
);

    logic s1;
    logic c1;
    logic c2;

    ha u_ha0 (.a(a),  .b(b),    .s(s1), .c(c1));
    ha u_ha1 (.a(s1), .b(c_in), .s(s),  .c(c2));

    // At most one of the two half adders can generate a carry.
    assign c = c1 | c2;

endmodule

module fa_serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sh_a_q;
    logic [WIDTH-1:0] sh_b_q;
    logic [WIDTH-1:0] sh_sum_q;
    logic [WIDTH-1:0] sh_sum_d;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             c_out_q;
    logic             busy_q;
    logic             done_q;
    logic             fa_s;
    logic             fa_c;

    // The one shared full adder always looks at the current LSBs and carry.
    fa_using_ha u_fa (
        .a    (sh_a_q[0]),
        .b    (sh_b_q[0]),
        .c_in (carry_q),
        .s    (fa_s),
        .c    (fa_c)
    );

    // Next sum-register value: new bit enters at the MSB while the register
    // shifts right, so after WIDTH bits the LSB of the result sits at bit 0.
    // Written as shift-and-or so it stays legal for WIDTH = 1.
    always_comb begin
        sh_sum_d = (sh_sum_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
    end

    // Sequencer: single registered FSM, all outputs are flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            sh_sum_q <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            c_out_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sh_a_q   <= a;
                        sh_b_q   <= b;
                        carry_q  <= c_in;
                        sh_sum_q <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end

                RUN: begin
                    sh_a_q   <= sh_a_q >> 1;
                    sh_b_q   <= sh_b_q >> 1;
                    sh_sum_q <= sh_sum_d;
                    carry_q  <= fa_c;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    // Last bit: publish the completed result in the same edge.
                    if (cnt_q == LAST_BIT) begin
                        sum_q   <= sh_sum_d;
                        c_out_q <= fa_c;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end

                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign c_out = c_out_q;

endmodule

// File: tb/tb_fa_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fa_serial_add_ctrl
//
// Directed bench for the bit-serial adder controller. An 8-bit instance
// runs a table of hand-computed additions plus the held-start, capture and
// mid-operation reset sequences; a 1-bit instance walks the full-adder
// truth table.
// ---------------------------------------------------------------------------

module tb_fa_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int vecCount  = 0;
    int missCount = 0;

    logic [7:0] prevSum;
    logic       prevCout;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] expSum;
        logic       expCout;
    } vec8_t;

    typedef struct {
        logic a;
        logic b;
        logic cin;
        logic expSum;
        logic expCout;
    } vec1_t;

    vec8_t vecs8[8];
    vec1_t vecs1[8];

    fa_serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .c_in  (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .c_out (cout8)
    );

    fa_serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .c_in  (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .c_out (cout1)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 8-bit operation with a single-cycle start pulse. Inputs are
    // scrambled after capture, and every cycle of the run is checked.
    task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb,
                                 input logic vc, input logic [7:0] es,
                                 input logic ec, input string tag);
        a8     = va;
        b8     = vb;
        cin8   = vc;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8     = ~va;
        b8     = ~vb;
        cin8   = ~vc;
        for (int i = 0; i < 8; i++) begin
            checkOutput({tag, " run"}, 32'({busy8, done8, cout8, sum8}),
                        32'({1'b1, 1'b0, prevCout, prevSum}));
            tick();
        end
        checkOutput({tag, " done"}, 32'({busy8, done8, cout8, sum8}),
                    32'({1'b0, 1'b1, ec, es}));
        tick();
        checkOutput({tag, " hold"}, 32'({busy8, done8, cout8, sum8}),
                    32'({1'b0, 1'b0, ec, es}));
        prevSum  = es;
        prevCout = ec;
    endtask

    // One 1-bit operation: busy for one cycle, then done.
    task automatic applyStimulus1(input vec1_t v, input int idx);
        a1     = v.a;
        b1     = v.b;
        cin1   = v.cin;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        a1     = ~v.a;
        b1     = ~v.b;
        cin1   = ~v.cin;
        checkOutput($sformatf("w1 run %0d", idx), 32'({busy1, done1}), 32'(2'b10));
        tick();
        checkOutput($sformatf("w1 done %0d", idx), 32'({busy1, done1, cout1, sum1}),
                    32'({1'b0, 1'b1, v.expCout, v.expSum}));
        tick();
        checkOutput($sformatf("w1 idle %0d", idx), 32'({busy1, done1}), 32'(2'b00));
    endtask

    // Main test sequence.
    initial begin
        logic [7:0] capA;
        logic [7:0] capB;
        logic       capC;
        logic [8:0] expTotal;

        vecs8[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
        vecs8[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs8[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs8[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs8[4] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        vecs8[5] = '{8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0};
        vecs8[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs8[7] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};

        vecs1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        rst_n    = 1'b0;
        start8   = 1'b0;
        a8       = '0;
        b8       = '0;
        cin8     = 1'b0;
        start1   = 1'b0;
        a1       = '0;
        b1       = '0;
        cin1     = 1'b0;
        prevSum  = '0;
        prevCout = 1'b0;

        #3;
        checkOutput("reset w8", 32'({busy8, done8, cout8, sum8}), 32'd0);
        checkOutput("reset w1", 32'({busy1, done1, cout1, sum1}), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("idle after reset", 32'({busy8, done8}), 32'd0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs8[i].a, vecs8[i].b, vecs8[i].cin,
                          vecs8[i].expSum, vecs8[i].expCout, $sformatf("vec%0d", i));
        end

        // start held high with operands changing every cycle: each result
        // must come from the captured operands, one accept per 10 cycles.
        start8 = 1'b1;
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        cin8   = 1'($urandom);
        for (int op = 0; op < 3; op++) begin
            capA     = a8;
            capB     = b8;
            capC     = cin8;
            expTotal = {1'b0, capA} + {1'b0, capB} + {8'b0, capC};
            tick();
            for (int i = 0; i < 8; i++) begin
                checkOutput($sformatf("held run %0d.%0d", op, i),
                            32'({busy8, done8}), 32'(2'b10));
                a8   = 8'($urandom);
                b8   = 8'($urandom);
                cin8 = 1'($urandom);
                tick();
            end
            checkOutput($sformatf("held done %0d", op),
                        32'({busy8, done8, cout8, sum8}), 32'({2'b01, expTotal}));
            a8   = 8'($urandom);
            b8   = 8'($urandom);
            cin8 = 1'($urandom);
            tick();
            checkOutput($sformatf("held gap %0d", op), 32'({busy8, done8}), 32'(2'b00));
            a8   = 8'($urandom);
            b8   = 8'($urandom);
            cin8 = 1'($urandom);
            prevSum  = expTotal[7:0];
            prevCout = expTotal[8];
        end
        start8 = 1'b0;
        tick();

        // Reset in the middle of an operation, asserted between edges.
        applyStimulus(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "pre-reset");
        a8     = 8'hAA;
        b8     = 8'h55;
        cin8   = 1'b0;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset mid-op", 32'({busy8, done8, cout8, sum8}), 32'd0);
        tick();
        checkOutput("reset held", 32'({busy8, done8, cout8, sum8}), 32'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("idle after mid-op reset", 32'({busy8, done8, cout8, sum8}), 32'd0);
        prevSum  = '0;
        prevCout = 1'b0;
        applyStimulus(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, "post-reset");

        // WIDTH = 1: full-adder truth table.
        for (int i = 0; i < 8; i++) begin
            applyStimulus1(vecs1[i], i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
